// File: rtl/c432_query_sequencer_if.sv
// Query/result handshake bundle between the oracle host and the c432 query sequencer.
interface c432_query_sequencer_if #(
    parameter int PI_W = 36,
    parameter int PO_W = 7
);
    logic            q_valid;
    logic            q_ready;
    logic [PI_W-1:0] q_pattern;
    logic            r_valid;
    logic            r_ready;
    logic [PO_W-1:0] r_data;

    // Host side: issues patterns, consumes results
    modport master (
        output q_valid, q_pattern, r_ready,
        input  q_ready, r_valid, r_data
    );

    // Sequencer side: accepts patterns, produces results
    modport slave (
        input  q_valid, q_pattern, r_ready,
        output q_ready, r_valid, r_data
    );
endinterface

// File: rtl/c432_query_sequencer.sv
// Sequences oracle queries into a key-gated c432: drives a pattern, waits a
// settle window, captures the outputs, and returns them. The key is loaded
// serially into a shadow register and only committed while no query is in flight.
module c432_query_sequencer #(
    parameter int PI_W   = 36,
    parameter int PO_W   = 7,
    parameter int KEY_W  = 2,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_shift_en,
    input  logic                  key_shift_bit,
    input  logic                  key_commit,
    output logic [KEY_W-1:0]      key_out,
    output logic                  key_pending,
    c432_query_sequencer_if.slave qif,
    output logic [PI_W-1:0]       pi_out,
    input  logic [PO_W-1:0]       po_in,
    output logic                  busy,
    output logic [CNT_W-1:0]      q_count
);
    typedef enum logic [1:0] {IDLE, APPLY, RESP} state_t;

    // SETTLE is limited to 1..15, so the countdown fits in 4 bits
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t           state;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] shadow_next;
    logic [3:0]       settle_cnt;
    logic             commit_now;

    // Shadow value including this cycle's serial bit, so a same-cycle commit sees it
    always_comb begin
        shadow_next = shadow;
        if (key_shift_en) begin
            shadow_next = {shadow[KEY_W-2:0], key_shift_bit};
        end
    end

    assign commit_now  = key_pending || key_commit;
    // A pending or arriving commit blocks acceptance so the key is applied first
    assign qif.q_ready = (state == IDLE) && !key_pending && !key_commit;

    // Key handling and the IDLE -> APPLY -> RESP query sequence with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            key_out     <= '0;
            key_pending <= 1'b0;
            pi_out      <= '0;
            settle_cnt  <= '0;
            qif.r_valid <= 1'b0;
            qif.r_data  <= '0;
            busy        <= 1'b0;
            q_count     <= '0;
        end else begin
            shadow <= shadow_next;
            if (key_commit) begin
                key_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (commit_now) begin
                        key_out     <= shadow_next;
                        key_pending <= 1'b0;
                    end else if (qif.q_valid) begin
                        pi_out     <= qif.q_pattern;
                        settle_cnt <= SETTLE_INIT;
                        busy       <= 1'b1;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        qif.r_data  <= po_in;
                        qif.r_valid <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (qif.r_ready) begin
                        qif.r_valid <= 1'b0;
                        busy        <= 1'b0;
                        q_count     <= q_count + CNT_W'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c432_query_sequencer.sv
// Directed bench for c432_query_sequencer: a transaction-level model is checked
// against the DUT every cycle, plus literal expectations from the test plan.
module tb_c432_query_sequencer;
    localparam int PI_W   = 36;
    localparam int PO_W   = 7;
    localparam int KEY_W  = 2;
    localparam int SETTLE = 2;
    // Narrow counter so the wrap-around is reached in a short run
    localparam int CNT_W  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_shift_en, key_shift_bit, key_commit;
    logic [KEY_W-1:0] key_out;
    logic             key_pending;
    logic [PI_W-1:0]  pi_out;
    logic [PO_W-1:0]  po_in;
    logic             busy;
    logic [CNT_W-1:0] q_count;

    c432_query_sequencer_if #(.PI_W(PI_W), .PO_W(PO_W)) qif ();

    c432_query_sequencer #(
        .PI_W(PI_W), .PO_W(PO_W), .KEY_W(KEY_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .key_shift_en(key_shift_en), .key_shift_bit(key_shift_bit), .key_commit(key_commit),
        .key_out(key_out), .key_pending(key_pending),
        .qif(qif),
        .pi_out(pi_out), .po_in(po_in),
        .busy(busy), .q_count(q_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one query in flight, result due SETTLE edges after acceptance
    bit               m_ok = 0;
    longint           cyc = 0;
    longint           m_cap;
    bit [KEY_W-1:0]   m_key, m_shadow, sh_n;
    bit               m_pending, m_busy, m_rv;
    bit [PO_W-1:0]    m_rd;
    bit [PI_W-1:0]    m_pi;
    int               m_cnt;

    always @(posedge clk) begin
        sh_n = key_shift_en ? {m_shadow[0], key_shift_bit} : m_shadow;
        if (rst) begin
            m_ok = 1; m_key = 0; m_shadow = 0; m_pending = 0; m_busy = 0;
            m_rv = 0; m_rd = 0; m_pi = 0; m_cnt = 0;
        end else begin
            if (!m_busy) begin
                if (m_pending || key_commit) begin
                    m_key = sh_n;
                    m_pending = 0;
                end else if (qif.q_valid) begin
                    m_pi = qif.q_pattern;
                    m_busy = 1;
                    m_cap = cyc + SETTLE;
                end
            end else begin
                if (key_commit) m_pending = 1;
                if (!m_rv) begin
                    if (cyc == m_cap) begin
                        m_rv = 1;
                        m_rd = po_in;
                    end
                end else if (qif.r_ready) begin
                    m_rv = 0;
                    m_busy = 0;
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end
            end
            m_shadow = sh_n;
        end
        cyc++;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_key_out", 64'(key_out), 64'(m_key));
            chk("m_key_pending", 64'(key_pending), 64'(m_pending));
            chk("m_q_ready", 64'(qif.q_ready), 64'(!m_busy && !m_pending && !key_commit));
            chk("m_pi_out", 64'(pi_out), 64'(m_pi));
            chk("m_r_valid", 64'(qif.r_valid), 64'(m_rv));
            chk("m_r_data", 64'(qif.r_data), 64'(m_rd));
            chk("m_busy", 64'(busy), 64'(m_busy));
            chk("m_q_count", 64'(q_count), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int b = 0;
        while (!qif.r_valid && b < 50) begin tick(); b++; end
        chk("result_timeout", 64'(b < 50), 64'd1);
        qif.r_ready = 1'b1;
        tick();
        qif.r_ready = 1'b0;
    endtask

    task automatic run_query(input logic [PI_W-1:0] pat, input logic [PO_W-1:0] po);
        int b = 0;
        qif.q_valid = 1'b1; qif.q_pattern = pat; po_in = po;
        while (!qif.q_ready && b < 50) begin tick(); b++; end
        chk("accept_timeout", 64'(b < 50), 64'd1);
        tick();
        qif.q_valid = 1'b0;
        drain();
    endtask

    initial begin
        int n, c;
        rst = 1'b1; key_shift_en = 0; key_shift_bit = 0; key_commit = 0;
        po_in = '0; qif.q_valid = 0; qif.q_pattern = '0; qif.r_ready = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_key_out", 64'(key_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_q_count", 64'(q_count), 64'd0);
        chk("rst_r_valid", 64'(qif.r_valid), 64'd0);

        // Shift 1,0 then commit
        key_shift_en = 1; key_shift_bit = 1; tick();
        key_shift_bit = 0; tick();
        key_shift_en = 0; key_commit = 1; #1;
        chk("commit_q_ready_low", 64'(qif.q_ready), 64'd0);
        tick();
        key_commit = 0; #1;
        chk("commit_key_out", 64'(key_out), 64'h2);
        chk("commit_pending", 64'(key_pending), 64'd0);
        chk("commit_q_ready_back", 64'(qif.q_ready), 64'd1);

        // Basic query, then back-pressure with changing po_in
        qif.q_valid = 1; qif.q_pattern = 36'h0_0000_0001; tick();
        qif.q_valid = 0; po_in = 7'h55;
        chk("q1_pi_out", 64'(pi_out), 64'h1);
        tick();
        chk("q1_not_yet", 64'(qif.r_valid), 64'd0);
        tick();
        chk("q1_r_valid", 64'(qif.r_valid), 64'd1);
        chk("q1_r_data", 64'(qif.r_data), 64'h55);
        po_in = 7'h2A;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_r_data", 64'(qif.r_data), 64'h55);
            chk("bp_r_valid", 64'(qif.r_valid), 64'd1);
            chk("bp_q_ready", 64'(qif.q_ready), 64'd0);
        end
        qif.r_ready = 1; tick(); qif.r_ready = 0;
        chk("q1_q_count", 64'(q_count), 64'd1);
        chk("q1_q_ready", 64'(qif.q_ready), 64'd1);
        chk("q1_r_valid_low", 64'(qif.r_valid), 64'd0);

        // Commit while a query is in flight
        qif.q_valid = 1; qif.q_pattern = 36'hA_5A5A_5A5A; po_in = 7'h11; tick();
        qif.q_valid = 0; key_shift_en = 1; key_shift_bit = 1; tick(); tick();
        key_shift_en = 0; key_commit = 1; tick();
        key_commit = 0;
        chk("fly_pending", 64'(key_pending), 64'd1);
        chk("fly_key_hold", 64'(key_out), 64'h2);
        chk("fly_r_valid", 64'(qif.r_valid), 64'd1);
        qif.q_valid = 1; qif.q_pattern = 36'h3_0000_00FF; qif.r_ready = 1; tick();
        qif.r_ready = 0;
        chk("fly_key_after_resp", 64'(key_out), 64'h2);
        chk("fly_q_ready_blocked", 64'(qif.q_ready), 64'd0);
        tick();
        chk("fly_key_applied", 64'(key_out), 64'h3);
        chk("fly_pending_clear", 64'(key_pending), 64'd0);
        chk("fly_not_accepted", 64'(busy), 64'd0);
        tick();
        chk("fly_accepted", 64'(busy), 64'd1);
        chk("fly_pi_out", 64'(pi_out), 64'h3_0000_00FF);
        qif.q_valid = 0;
        drain();

        // Simultaneous query and commit in IDLE
        key_shift_en = 1; key_shift_bit = 0; tick(); key_shift_en = 0;
        qif.q_valid = 1; qif.q_pattern = 36'hF_0F0F_0F0F; key_commit = 1; #1;
        chk("sim_q_ready", 64'(qif.q_ready), 64'd0);
        tick();
        key_commit = 0;
        chk("sim_key_out", 64'(key_out), 64'h2);
        chk("sim_not_accepted", 64'(busy), 64'd0);
        tick();
        chk("sim_accepted", 64'(busy), 64'd1);
        chk("sim_pi_out", 64'(pi_out), 64'hF_0F0F_0F0F);
        qif.q_valid = 0;
        drain();

        // Reset while holding a result with a commit pending
        qif.q_valid = 1; qif.q_pattern = 36'h1_2345_6789; po_in = 7'h7F; tick();
        qif.q_valid = 0;
        n = 0;
        while (!qif.r_valid && n < 50) begin tick(); n++; end
        key_commit = 1; tick(); key_commit = 0;
        chk("rr_pending", 64'(key_pending), 64'd1);
        rst = 1; tick(); rst = 0;
        chk("rr_key_out", 64'(key_out), 64'd0);
        chk("rr_pending_cleared", 64'(key_pending), 64'd0);
        chk("rr_pi_out", 64'(pi_out), 64'd0);
        chk("rr_r_valid", 64'(qif.r_valid), 64'd0);
        chk("rr_r_data", 64'(qif.r_data), 64'd0);
        chk("rr_busy", 64'(busy), 64'd0);
        chk("rr_q_count", 64'(q_count), 64'd0);
        run_query(36'h8_0000_0000, 7'h13);
        chk("rr_after_count", 64'(q_count), 64'd1);
        chk("rr_after_data", 64'(qif.r_data), 64'h13);

        // Back-to-back queries until the counter wraps
        rst = 1; tick(); rst = 0;
        qif.q_valid = 1; qif.r_ready = 1;
        n = 0; c = 0;
        while (n < (1 << CNT_W) && c < 20000) begin
            @(negedge clk);
            if (qif.r_valid) n++;
            c++;
            po_in = PO_W'($urandom);
            qif.q_pattern = {4'($urandom), 32'($urandom)};
        end
        @(posedge clk); #1;
        qif.q_valid = 0; qif.r_ready = 0;
        chk("wrap_done", 64'(n), 64'(1 << CNT_W));
        chk("wrap_q_count", 64'(q_count), 64'd0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
